// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Writeback arbiter in front of the register-file write port.
//             In-order pipeline results win by default; long-latency
//             results queue in a small FIFO. The FIFO head is forced through
//             once it has starved for STARVE_LIMIT cycles. A per-register
//             busy mask exposes destinations still waiting in the FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int REG_SIZE     = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       pipe_valid_i,
  input  logic [ADDR_WIDTH-1:0]      pipe_rd_i,
  input  logic [REG_SIZE-1:0]        pipe_data_i,
  input  logic                       lu_valid_i,
  output logic                       lu_ready_o,
  input  logic [ADDR_WIDTH-1:0]      lu_rd_i,
  input  logic [REG_SIZE-1:0]        lu_data_i,
  output logic                       write_o,
  output logic [ADDR_WIDTH-1:0]      waddr_o,
  output logic [REG_SIZE-1:0]        wdata_o,
  output logic [2**ADDR_WIDTH-1:0]   busy_regs_o,
  output logic                       stall_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREGS = 2**ADDR_WIDTH;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] r_fifo_rd   [DEPTH];
  logic [REG_SIZE-1:0]   r_fifo_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [STV_W-1:0]      r_starve_cnt;
  logic                  r_stall;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [REG_SIZE-1:0]   r_wdata;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pipe_win;
  logic                  w_pop;
  logic [STV_W-1:0]      w_starve_nxt;
  logic [NREGS-1:0]      w_busy;

  // Readiness comes only from the registered count, so a same-cycle pop
  // never opens a slot for a push while full.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign lu_ready_o = ~w_full;

  // x0 results are handshaken but never stored.
  assign w_push     = lu_valid_i & ~w_full & (lu_rd_i != '0);

  // Pipeline wins unless the head is starving; during a stall the head is
  // forced out regardless of pipe_valid_i.
  assign w_pipe_win = ~r_stall & pipe_valid_i & (pipe_rd_i != '0);
  assign w_pop      = ~w_empty & ~w_pipe_win;

  // FIFO payload storage; contents are qualified by r_valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= lu_rd_i;
      r_fifo_data[r_wptr] <= lu_data_i;
    end
  end

  // FIFO pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_rptr          <= r_rptr + PTR_W'(1);
        r_valid[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_wptr          <= r_wptr + PTR_W'(1);
        r_valid[r_wptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Age of the current head: counts waiting cycles, saturates at the limit.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != STV_W'(STARVE_LIMIT)) begin
      w_starve_nxt = r_starve_cnt + STV_W'(1);
    end
  end

  // Starvation counter and registered stall flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_stall      <= (w_starve_nxt == STV_W'(STARVE_LIMIT));
    end
  end

  // Register-file write port; address/data hold when nothing wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_write <= w_pipe_win | w_pop;
      if (w_pipe_win) begin
        r_waddr <= pipe_rd_i;
        r_wdata <= pipe_data_i;
      end else if (w_pop) begin
        r_waddr <= r_fifo_rd[r_rptr];
        r_wdata <= r_fifo_data[r_rptr];
      end
    end
  end

  // Busy mask: OR of one-hot destinations over live FIFO slots.
  always_comb begin
    w_busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[k]) begin
        w_busy[r_fifo_rd[k]] = 1'b1;
      end
    end
  end

  assign busy_regs_o = w_busy;
  assign stall_o     = r_stall;
  assign write_o     = r_write;
  assign waddr_o     = r_waddr;
  assign wdata_o     = r_wdata;

endmodule
`default_nettype wire
